// File: rtl/fpaddsub_pack_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fpaddsub_pack_stage
//  Purpose  : FP add/sub output stage. Resolves special cases, overflow and
//             underflow on the rounded result, packs an IEEE-754 single word,
//             and presents it through a valid/ready port with a 2-entry skid
//             buffer and sticky exception flags.
//  Revision : 1.0  initial release
// ============================================================================
module fpaddsub_pack_stage #(
  parameter logic [31:0] QNAN         = 32'h7FC00000,
  parameter int          FLUSH_DENORM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic        Sgn,
  input  logic [8:0]  RoundE,
  input  logic [22:0] RoundM,
  input  logic        Inexact,
  input  logic [1:0]  Special,
  input  logic [1:0]  RoundMode,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] Result,
  output logic [3:0]  OutFlags,
  output logic [3:0]  StickyFlags,
  input  logic        FlagClr
);

  // Special-case class encoding
  localparam logic [1:0] c_SPC_NORMAL  = 2'b00;
  localparam logic [1:0] c_SPC_INF     = 2'b01;
  localparam logic [1:0] c_SPC_INVALID = 2'b10;

  // Rounding mode encoding
  localparam logic [1:0] c_RM_RNE  = 2'b00;
  localparam logic [1:0] c_RM_PINF = 2'b01;
  localparam logic [1:0] c_RM_NINF = 2'b11;

  // Occupancy of the main/skid register pair
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        in_ready_q;
  logic [31:0] main_res_q, skid_res_q;
  logic [3:0]  main_flg_q, skid_flg_q;
  logic [3:0]  sticky_q, sticky_d;

  logic [31:0] w_pack_res;
  logic [3:0]  w_pack_flg;
  logic        w_ovf;
  logic        w_to_inf;
  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_load_main_in;
  logic        w_load_main_skid;
  logic        w_load_skid;

  // Pack the incoming rounded fields into a result word and its flag set
  always_comb begin
    w_pack_res = {Sgn, RoundE[7:0], RoundM};
    w_pack_flg = {3'b000, Inexact};
    w_ovf      = RoundE[8] | (&RoundE[7:0]);
    // Overflow goes to infinity only when rounding points away from zero
    w_to_inf   = (RoundMode == c_RM_RNE) |
                 ((RoundMode == c_RM_PINF) & ~Sgn) |
                 ((RoundMode == c_RM_NINF) & Sgn);
    if (Special == c_SPC_INVALID) begin
      w_pack_res = QNAN;
      w_pack_flg = 4'b1000;
    end else if (Special == c_SPC_INF) begin
      w_pack_res = {Sgn, 8'hFF, 23'h0};
      w_pack_flg = 4'b0000;
    end else if (Special != c_SPC_NORMAL) begin
      // Exact zero: any inexact indication from upstream is meaningless here
      w_pack_res = {Sgn, 31'h0};
      w_pack_flg = 4'b0000;
    end else if (w_ovf) begin
      w_pack_res = w_to_inf ? {Sgn, 8'hFF, 23'h0} : {Sgn, 8'hFE, 23'h7FFFFF};
      w_pack_flg = 4'b0101;
    end else if (RoundE == 9'd0) begin
      if (FLUSH_DENORM != 0) begin
        w_pack_res = {Sgn, 31'h0};
        w_pack_flg = 4'b0011;
      end else begin
        w_pack_res = {Sgn, 8'h00, RoundM};
        w_pack_flg = {2'b00, Inexact, Inexact};
      end
    end
  end

  assign w_in_xfer  = InValid & in_ready_q;
  assign w_out_xfer = (state_q != EMPTY) & OutReady;

  // Occupancy next-state and register load selects
  always_comb begin
    state_d          = state_q;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (w_in_xfer) begin
          state_d        = ONE;
          w_load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (w_in_xfer & ~w_out_xfer) begin
          state_d     = TWO;
          w_load_skid = 1'b1;
        end else if (w_in_xfer & w_out_xfer) begin
          w_load_main_in = 1'b1;
        end else if (w_out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // Input side is closed while full, so only the drain matters
        if (w_out_xfer) begin
          state_d          = ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Sticky flags: a clear takes effect before the flags of a same-cycle transfer
  always_comb begin
    sticky_d = FlagClr ? 4'b0000 : sticky_q;
    if (w_out_xfer) begin
      sticky_d = sticky_d | main_flg_q;
    end
  end

  // State, data registers and ready flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_res_q <= 32'h0;
      main_flg_q <= 4'h0;
      skid_res_q <= 32'h0;
      skid_flg_q <= 4'h0;
      sticky_q   <= 4'h0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      sticky_q   <= sticky_d;
      if (w_load_main_in) begin
        main_res_q <= w_pack_res;
        main_flg_q <= w_pack_flg;
      end else if (w_load_main_skid) begin
        main_res_q <= skid_res_q;
        main_flg_q <= skid_flg_q;
      end
      if (w_load_skid) begin
        skid_res_q <= w_pack_res;
        skid_flg_q <= w_pack_flg;
      end
    end
  end

  assign InReady     = in_ready_q;
  assign OutValid    = (state_q != EMPTY);
  assign Result      = main_res_q;
  assign OutFlags    = main_flg_q;
  assign StickyFlags = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_fpaddsub_pack_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpaddsub_pack_stage
//  Purpose  : Directed self-checking bench for fpaddsub_pack_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpaddsub_pack_stage;

  logic        clk;
  logic        rst_n;
  logic        InValid;
  logic        InReady;
  logic        Sgn;
  logic [8:0]  RoundE;
  logic [22:0] RoundM;
  logic        Inexact;
  logic [1:0]  Special;
  logic [1:0]  RoundMode;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Result;
  logic [3:0]  OutFlags;
  logic [3:0]  StickyFlags;
  logic        FlagClr;

  int tests = 0;
  int fails = 0;

  fpaddsub_pack_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .InValid     (InValid),
    .InReady     (InReady),
    .Sgn         (Sgn),
    .RoundE      (RoundE),
    .RoundM      (RoundM),
    .Inexact     (Inexact),
    .Special     (Special),
    .RoundMode   (RoundMode),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .Result      (Result),
    .OutFlags    (OutFlags),
    .StickyFlags (StickyFlags),
    .FlagClr     (FlagClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, land on the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic [8:0] e, input logic [22:0] m,
                       input logic ix, input logic [1:0] sp, input logic [1:0] rm);
    InValid   = 1'b1;
    Sgn       = s;
    RoundE    = e;
    RoundM    = m;
    Inexact   = ix;
    Special   = sp;
    RoundMode = rm;
  endtask

  // One result through an empty stage with OutReady high
  task automatic send_one(input string tag, input logic s, input logic [8:0] e,
                          input logic [22:0] m, input logic ix, input logic [1:0] sp,
                          input logic [1:0] rm, input logic [31:0] er, input logic [3:0] ef);
    drive(s, e, m, ix, sp, rm);
    step();
    InValid = 1'b0;
    chk({tag, "_valid"}, {31'h0, OutValid}, 32'h1);
    chk({tag, "_result"}, Result, er);
    chk({tag, "_flags"}, {28'h0, OutFlags}, {28'h0, ef});
    step();
    chk({tag, "_drained"}, {31'h0, OutValid}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b1; FlagClr = 1'b0;
    Sgn = 1'b0; RoundE = 9'h0; RoundM = 23'h0; Inexact = 1'b0;
    Special = 2'b00; RoundMode = 2'b00;
    @(negedge clk);
    step();
    step();
    chk("rst_valid",  {31'h0, OutValid}, 32'h0);
    chk("rst_result", Result, 32'h0);
    chk("rst_flags",  {28'h0, OutFlags}, 32'h0);
    chk("rst_sticky", {28'h0, StickyFlags}, 32'h0);
    chk("rst_inready", {31'h0, InReady}, 32'h1);
    rst_n = 1'b1;
    step();

    // Pack function directed vectors
    send_one("normal",    1'b0, 9'h080, 23'h400000, 1'b1, 2'b00, 2'b00, 32'h40400000, 4'b0001);
    send_one("ovf_rz",    1'b1, 9'h0FF, 23'h000000, 1'b0, 2'b00, 2'b10, 32'hFF7FFFFF, 4'b0101);
    send_one("ovf_ninf",  1'b1, 9'h0FF, 23'h000000, 1'b0, 2'b00, 2'b11, 32'hFF800000, 4'b0101);
    send_one("ovf_pinf_neg", 1'b1, 9'h100, 23'h123456, 1'b0, 2'b00, 2'b01, 32'hFF7FFFFF, 4'b0101);
    send_one("ovf_rne",   1'b0, 9'h1FF, 23'h000001, 1'b0, 2'b00, 2'b00, 32'h7F800000, 4'b0101);
    send_one("invalid",   1'b0, 9'h080, 23'h000000, 1'b1, 2'b10, 2'b00, 32'h7FC00000, 4'b1000);
    send_one("zero_neg",  1'b1, 9'h080, 23'h7FFFFF, 1'b1, 2'b11, 2'b00, 32'h80000000, 4'b0000);
    send_one("inf_neg",   1'b1, 9'h000, 23'h000000, 1'b1, 2'b01, 2'b00, 32'hFF800000, 4'b0000);
    send_one("flush",     1'b0, 9'h000, 23'h000123, 1'b0, 2'b00, 2'b00, 32'h00000000, 4'b0011);
    send_one("max_exact", 1'b0, 9'h0FE, 23'h7FFFFF, 1'b0, 2'b00, 2'b00, 32'h7F7FFFFF, 4'b0000);
    chk("sticky_all", {28'h0, StickyFlags}, 32'hF);

    // FlagClr alone
    FlagClr = 1'b1;
    step();
    FlagClr = 1'b0;
    chk("sticky_clr", {28'h0, StickyFlags}, 32'h0);

    // Overflow then inexact accumulates
    send_one("stk_ovf", 1'b0, 9'h0FF, 23'h0, 1'b0, 2'b00, 2'b10, 32'h7F7FFFFF, 4'b0101);
    send_one("stk_inx", 1'b0, 9'h07F, 23'h0, 1'b1, 2'b00, 2'b00, 32'h3F800000, 4'b0001);
    chk("sticky_accum", {28'h0, StickyFlags}, 32'h5);

    // FlagClr coincident with an invalid transfer
    drive(1'b0, 9'h080, 23'h0, 1'b0, 2'b10, 2'b00);
    step();
    InValid = 1'b0;
    FlagClr = 1'b1;
    step();
    FlagClr = 1'b0;
    chk("sticky_clr_xfer", {28'h0, StickyFlags}, 32'h8);

    // Backpressure: four results, OutReady low for three edges
    OutReady = 1'b0;
    drive(1'b0, 9'h081, 23'h000001, 1'b0, 2'b00, 2'b00);
    step();
    chk("bp_a_result", Result, 32'h40800001);
    chk("bp_a_inready", {31'h0, InReady}, 32'h1);
    drive(1'b0, 9'h081, 23'h000002, 1'b0, 2'b00, 2'b00);
    step();
    chk("bp_two_inready", {31'h0, InReady}, 32'h0);
    chk("bp_hold1", Result, 32'h40800001);
    drive(1'b0, 9'h081, 23'h000003, 1'b0, 2'b00, 2'b00);
    step();
    chk("bp_hold2", Result, 32'h40800001);
    chk("bp_hold_valid", {31'h0, OutValid}, 32'h1);
    chk("bp_still_full", {31'h0, InReady}, 32'h0);
    OutReady = 1'b1;
    step();
    chk("bp_b_result", Result, 32'h40800002);
    chk("bp_b_inready", {31'h0, InReady}, 32'h1);
    step();
    chk("bp_c_result", Result, 32'h40800003);
    drive(1'b0, 9'h081, 23'h000004, 1'b0, 2'b00, 2'b00);
    step();
    InValid = 1'b0;
    chk("bp_d_result", Result, 32'h40800004);
    chk("bp_d_valid", {31'h0, OutValid}, 32'h1);
    step();
    chk("bp_empty", {31'h0, OutValid}, 32'h0);
    chk("bp_sticky", {28'h0, StickyFlags}, 32'h8);

    // Reset with two entries buffered
    OutReady = 1'b0;
    drive(1'b0, 9'h0FF, 23'h0, 1'b0, 2'b00, 2'b00);
    step();
    drive(1'b0, 9'h080, 23'h0, 1'b1, 2'b00, 2'b00);
    step();
    InValid = 1'b0;
    chk("rst2_full", {31'h0, InReady}, 32'h0);
    rst_n = 1'b0;
    step();
    chk("rst2_valid", {31'h0, OutValid}, 32'h0);
    chk("rst2_sticky", {28'h0, StickyFlags}, 32'h0);
    chk("rst2_result", Result, 32'h0);
    chk("rst2_inready", {31'h0, InReady}, 32'h1);
    rst_n = 1'b1;
    OutReady = 1'b1;
    step();
    chk("rst2_no_stale", {31'h0, OutValid}, 32'h0);
    send_one("post_rst", 1'b1, 9'h080, 23'h200000, 1'b0, 2'b00, 2'b01, 32'hC0200000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
